operand_pair_joiner: RTL and testbench

Upstream stage of the parallel floating-point adder: joins two independent operand streams, A and B, into one lock-stepped stream of (A, B) beat pairs. Each side is a valid/ready/tlast stream carrying PARALLELISM lanes of BIT_SIZE bits. Each side is buffered independently so either producer can run ahead by up to DEPTH beats. The block detects packet-boundary disagreement between the two sides and resynchronises on the next boundary, so the adder only ever sees aligned beats.

---
 rtl/operand_pair_joiner.sv | 189 ++++++++++++++++++
 tb/tb_operand_pair_joiner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_pair_joiner.sv
// operand_pair_joiner
//   Joins two independent valid/ready/tlast operand streams (A and B) into one
//   lock-stepped stream of (A, B) beat pairs for the parallel FP adder. Each
//   side has its own fall-through FIFO so either producer may run ahead by up
//   to DEPTH beats. When the two heads disagree on tlast, the pair is still
//   emitted (closing the packet), err is set, and the longer side is drained
//   up to and including its own tlast before pairing resumes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a/valid_a/ready_a/tlast_a  side-A lanes and handshake
//   b/valid_b/ready_b/tlast_b  side-B lanes and handshake
//   out_a, out_b             paired operands (FIFO heads)
//   valid/ready/tlast        paired-stream handshake
//   err                      sticky tlast-mismatch flag (cleared by rst only)
//   pkt_cnt, mis_cnt         packet / mismatch counters
//
// Build option
//   OPERAND_PAIR_JOINER_STATS_EN: when defined, pkt_cnt (wrapping) and
//   mis_cnt (saturating) are live; otherwise both ports are tied to 0.

// Circular FIFO with fall-through head and registered occupancy count.
module operand_pair_joiner_fifo #(
  parameter int W     = 97,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: only entries counted by cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

module operand_pair_joiner #(
  parameter int PARALLELISM = 3,
  parameter int BIT_SIZE    = 32,
  parameter int DEPTH       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_SIZE-1:0] a [PARALLELISM-1:0],
  input  logic                valid_a,
  output logic                ready_a,
  input  logic                tlast_a,
  input  logic [BIT_SIZE-1:0] b [PARALLELISM-1:0],
  input  logic                valid_b,
  output logic                ready_b,
  input  logic                tlast_b,
  output logic [BIT_SIZE-1:0] out_a [PARALLELISM-1:0],
  output logic [BIT_SIZE-1:0] out_b [PARALLELISM-1:0],
  output logic                valid,
  input  logic                ready,
  output logic                tlast,
  output logic                err,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         mis_cnt
);
  localparam int DW = PARALLELISM * BIT_SIZE;
  localparam int EW = DW + 1;  // lanes plus tlast

  typedef enum logic [1:0] {RUN, RESYNC_A, RESYNC_B} state_t;

  state_t        state_q;
  logic          err_q;
  logic [EW-1:0] wdata_a, wdata_b, head_a, head_b;
  logic          empty_a, empty_b, full_a, full_b;
  logic          push_a, push_b, pop_a, pop_b;
  logic          hl_a, hl_b, mism, xfer;

  // Pack lanes and tlast into one FIFO word per side.
  for (genvar l = 0; l < PARALLELISM; l++) begin : g_lane
    assign wdata_a[l*BIT_SIZE +: BIT_SIZE] = a[l];
    assign wdata_b[l*BIT_SIZE +: BIT_SIZE] = b[l];
    assign out_a[l] = head_a[l*BIT_SIZE +: BIT_SIZE];
    assign out_b[l] = head_b[l*BIT_SIZE +: BIT_SIZE];
  end
  assign wdata_a[DW] = tlast_a;
  assign wdata_b[DW] = tlast_b;

  // ready depends only on registered occupancy, never on downstream ready.
  assign ready_a = !full_a && !rst;
  assign ready_b = !full_b && !rst;
  assign push_a  = valid_a && ready_a;
  assign push_b  = valid_b && ready_b;

  operand_pair_joiner_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push_i(push_a), .wdata_i(wdata_a), .pop_i(pop_a),
    .rdata_o(head_a), .empty_o(empty_a), .full_o(full_a)
  );
  operand_pair_joiner_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push_i(push_b), .wdata_i(wdata_b), .pop_i(pop_b),
    .rdata_o(head_b), .empty_o(empty_b), .full_o(full_b)
  );

  assign hl_a = head_a[DW];
  assign hl_b = head_b[DW];
  assign mism = hl_a ^ hl_b;

  // On disagreement the pair still closes the packet, hence the OR.
  assign valid = (state_q == RUN) && !empty_a && !empty_b && !rst;
  assign tlast = valid && (hl_a || hl_b);
  assign xfer  = valid && ready;

  // Resync drains the longer side regardless of downstream ready.
  assign pop_a = xfer || ((state_q == RESYNC_A) && !empty_a);
  assign pop_b = xfer || ((state_q == RESYNC_B) && !empty_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (xfer && mism) begin
            err_q   <= 1'b1;
            // The side whose head lacked tlast still has beats of this packet.
            state_q <= hl_a ? RESYNC_B : RESYNC_A;
          end
        end
        RESYNC_A: if (!empty_a && hl_a) state_q <= RUN;
        RESYNC_B: if (!empty_b && hl_b) state_q <= RUN;
        default:  state_q <= RUN;
      endcase
    end
  end

  assign err = err_q;

`ifdef OPERAND_PAIR_JOINER_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d, mis_cnt_q, mis_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    mis_cnt_d = mis_cnt_q;
    // tlast covers both agreed ends and mismatch-closed packets.
    if (xfer && tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (xfer && mism && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign mis_cnt = mis_cnt_q;
`else
  assign pkt_cnt = '0;
  assign mis_cnt = '0;
`endif
endmodule

// File: tb/tb_operand_pair_joiner.sv
// Bench for operand_pair_joiner: table of packet pairs plus hand sequences
// for skew, full-FIFO streaming and reset mid-packet.
module tb_operand_pair_joiner;
  localparam int P = 3;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] a [P-1:0];
  logic [W-1:0] b [P-1:0];
  logic [W-1:0] out_a [P-1:0];
  logic [W-1:0] out_b [P-1:0];
  logic valid_a = 1'b0, tlast_a = 1'b0, ready_a;
  logic valid_b = 1'b0, tlast_b = 1'b0, ready_b;
  logic valid, tlast, err;
  logic ready = 1'b0;
  logic [15:0] pkt_cnt, mis_cnt;

  operand_pair_joiner #(.PARALLELISM(P), .BIT_SIZE(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .a(a), .valid_a(valid_a), .ready_a(ready_a), .tlast_a(tlast_a),
    .b(b), .valid_b(valid_b), .ready_b(ready_b), .tlast_b(tlast_b),
    .out_a(out_a), .out_b(out_b),
    .valid(valid), .ready(ready), .tlast(tlast), .err(err),
    .pkt_cnt(pkt_cnt), .mis_cnt(mis_cnt)
  );

  typedef struct packed { logic [31:0] v; logic last; } beat_t;
  typedef struct packed { logic [31:0] va; logic [31:0] vb; logic last; } pair_t;
  typedef struct { int la; int lb; int a0; int b0; int mode;
                   int exp_pairs; int exp_err; int exp_pkt; int exp_mis; } vec_t;

  beat_t qa[$];
  beat_t qb[$];
  pair_t exp_q[$];
  int nvec = 0, nfail = 0, n_pairs = 0;
  bit en_a = 1'b1, en_b = 1'b1;
  int rdy_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low

  function automatic logic [31:0] lane_a(logic [31:0] v, int k);
    return v + (32'(k) << 16);
  endfunction
  function automatic logic [31:0] lane_b(logic [31:0] v, int k);
    return v + (32'(k) << 20);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Packet-level model: pair beat-for-beat up to the shorter packet, the last
  // pair closes the packet, the remainder of the longer packet is discarded.
  task automatic push_row(int la, int lb, int a0, int b0);
    beat_t x;
    pair_t p;
    int n;
    n = (la < lb) ? la : lb;
    for (int i = 0; i < la; i++) begin
      x.v = 32'(a0 + i); x.last = (i == la - 1); qa.push_back(x);
    end
    for (int i = 0; i < lb; i++) begin
      x.v = 32'(b0 + 10 * i); x.last = (i == lb - 1); qb.push_back(x);
    end
    for (int i = 0; i < n; i++) begin
      p.va = 32'(a0 + i); p.vb = 32'(b0 + 10 * i); p.last = (i == n - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic wait_drain(string name);
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0 || exp_q.size() != 0) && t < 400) begin
      @(posedge clk);
      t++;
    end
    nvec++;
    if (t >= 400) begin
      nfail++;
      $display("FAIL %s drain timeout: qa=%0d qb=%0d pending=%0d, required all 0",
               name, qa.size(), qb.size(), exp_q.size());
      qa.delete(); qb.delete(); exp_q.delete();
    end
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
  endtask

  // Side drivers: a beat leaves the queue once the DUT accepted it.
  initial begin : drv_a
    bit acc_a;
    for (int k = 0; k < P; k++) a[k] = '0;
    forever begin
      @(negedge clk); acc_a = valid_a && ready_a;
      @(posedge clk); #1;
      if (acc_a && qa.size() > 0) qa.delete(0);
      if (en_a && qa.size() > 0) begin
        valid_a = 1'b1; tlast_a = qa[0].last;
        for (int k = 0; k < P; k++) a[k] = lane_a(qa[0].v, k);
      end else valid_a = 1'b0;
    end
  end

  initial begin : drv_b
    bit acc_b;
    for (int k = 0; k < P; k++) b[k] = '0;
    forever begin
      @(negedge clk); acc_b = valid_b && ready_b;
      @(posedge clk); #1;
      if (acc_b && qb.size() > 0) qb.delete(0);
      if (en_b && qb.size() > 0) begin
        valid_b = 1'b1; tlast_b = qb[0].last;
        for (int k = 0; k < P; k++) b[k] = lane_b(qb[0].v, k);
      end else valid_b = 1'b0;
    end
  end

  initial begin : drv_rdy
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       ready = 1'b1;
        1:       ready = !ready;
        2:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard on every transfer, plus a stalled pair must hold.
  initial begin : mon
    pair_t e;
    bit ok;
    logic pv, pr, plast;
    logic [31:0] pa0, pb0;
    pv = 1'b0; pr = 1'b0; plast = 1'b0; pa0 = '0; pb0 = '0;
    forever begin
      @(negedge clk);
      if (!rst && pv && !pr) begin
        nvec++;
        if (!(valid === 1'b1 && out_a[0] === pa0 && out_b[0] === pb0 && tlast === plast)) begin
          nfail++;
          $display("FAIL hold: valid=%0b a0=%0h b0=%0h tlast=%0b, required 1 %0h %0h %0b",
                   valid, out_a[0], out_b[0], tlast, pa0, pb0, plast);
        end
      end
      if (valid === 1'b1 && ready === 1'b1) begin
        n_pairs++;
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL pair: unexpected a0=%0h b0=%0h tlast=%0b, required none",
                   out_a[0], out_b[0], tlast);
        end else begin
          e = exp_q.pop_front();
          ok = (tlast === e.last);
          for (int k = 0; k < P; k++)
            ok = ok && (out_a[k] === lane_a(e.va, k)) && (out_b[k] === lane_b(e.vb, k));
          if (!ok) begin
            nfail++;
            $display("FAIL pair: got a0=%0h b0=%0h tlast=%0b, required a0=%0h b0=%0h tlast=%0b",
                     out_a[0], out_b[0], tlast, e.va, e.vb, e.last);
          end
        end
      end
      pv = (valid === 1'b1) && !rst; pr = ready; plast = tlast; pa0 = out_a[0]; pb0 = out_b[0];
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail + 1);
    $fatal(1, "watchdog");
  end

  function automatic int cnt_exp(int v);
`ifdef OPERAND_PAIR_JOINER_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  initial begin : main
    vec_t tbl [8];
    int n0, n1, t;
    tbl[0] = '{4, 4,    1,   10, 0, 4, 0, 1, 0};
    tbl[1] = '{5, 5,  100,  200, 2, 5, 0, 2, 0};
    tbl[2] = '{3, 2,  300,  400, 0, 2, 1, 3, 1};
    tbl[3] = '{2, 2,  500,  600, 0, 2, 1, 4, 1};
    tbl[4] = '{2, 2,  700,  800, 1, 2, 1, 5, 1};
    tbl[5] = '{1, 3,  900, 1000, 0, 1, 1, 6, 2};
    tbl[6] = '{4, 6, 1100, 1200, 1, 4, 1, 7, 3};
    tbl[7] = '{1, 1, 1300, 1400, 2, 1, 1, 8, 3};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready_a", ready_a, 0);
    check("rst_ready_b", ready_b, 0);
    check("rst_valid", valid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_err", err, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_mis_cnt", mis_cnt, 0);
    rst = 1'b0;

    // Table of packet pairs
    for (int r = 0; r < 8; r++) begin
      rdy_mode = tbl[r].mode;
      n0 = n_pairs;
      push_row(tbl[r].la, tbl[r].lb, tbl[r].a0, tbl[r].b0);
      wait_drain("row");
      check("row_pairs", n_pairs - n0, tbl[r].exp_pairs);
      check("row_err", err, tbl[r].exp_err);
      check("row_pkt_cnt", pkt_cnt, cnt_exp(tbl[r].exp_pkt));
      check("row_mis_cnt", mis_cnt, cnt_exp(tbl[r].exp_mis));
    end

    // Skew: A runs 6 beats ahead while B is silent, ready toggling
    rdy_mode = 1;
    en_b = 1'b0;
    n0 = n_pairs;
    push_row(6, 6, 6000, 7000);
    repeat (10) @(negedge clk); #1;
    check("skew_ready_a", ready_a, 0);
    check("skew_accepted", 6 - qa.size(), 4);
    check("skew_valid", valid, 0);
    en_b = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    check("skew_latency_valid", valid, 1);
    wait_drain("skew");
    check("skew_pairs", n_pairs - n0, 6);
    check("skew_pkt_cnt", pkt_cnt, cnt_exp(9));

    // Full FIFOs, then stream with push and pop in the same cycle
    rdy_mode = 3;
    @(posedge clk); @(negedge clk); #1;
    n0 = n_pairs;
    push_row(12, 12, 8000, 9000);
    t = 0;
    while ((ready_a || ready_b) && t < 40) begin @(negedge clk); #1; t++; end
    check("full_reached", {ready_a, ready_b}, 2'b00);
    check("full_valid", valid, 1);
    rdy_mode = 0;
    @(posedge clk);
    n1 = n_pairs;
    repeat (12) @(negedge clk);
    #1;
    check("full_throughput", n_pairs - n1, 12);
    wait_drain("full");
    check("full_pairs", n_pairs - n0, 12);
    check("full_pkt_cnt", pkt_cnt, cnt_exp(10));

    // Reset after two beats buffered per side
    rdy_mode = 3;
    @(posedge clk); @(negedge clk); #1;
    push_row(4, 4, 20000, 30000);
    t = 0;
    while ((qa.size() > 2 || qb.size() > 2) && t < 40) begin @(negedge clk); #1; t++; end
    check("pre_rst_valid", valid, 1);
    check("pre_rst_err", err, 1);
    rst = 1'b1;
    qa.delete(); qb.delete(); exp_q.delete();
    @(posedge clk); @(negedge clk); #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ready_a", ready_a, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_mis_cnt", mis_cnt, 0);
    rst = 1'b0;
    rdy_mode = 0;
    n0 = n_pairs;
    push_row(3, 3, 40000, 50000);
    wait_drain("post_rst");
    check("post_rst_pairs", n_pairs - n0, 3);
    check("post_rst_err", err, 0);
    check("post_rst_pkt_cnt", pkt_cnt, cnt_exp(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
